lead_one_placer_pipe: RTL and testbench



---
 rtl/pof_lod_pkg.sv | 16 +
 rtl/elastic_pipe_stage.sv | 46 ++++
 rtl/lead_one_placer_pipe.sv | 85 ++++++++
 tb/tb_lead_one_placer_pipe.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pof_lod_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pof_lod_pkg
//  Purpose  : Shared types for the leading-one detector / placer pair.
//  Revision : 1.0  initial release
// ============================================================================
package pof_lod_pkg;

    localparam int LOD_WIDTH = 16;
    localparam int LOD_LOG   = 4;

    typedef logic [LOD_LOG-1:0]   lod_pos_t;
    typedef logic [LOD_WIDTH-1:0] lod_word_t;

endpackage : pof_lod_pkg
`default_nettype wire

// File: rtl/elastic_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : elastic_pipe_stage
//  Purpose  : One valid/ready register slice; holds data stable under stall.
//  Revision : 1.0  initial release
// ============================================================================
module elastic_pipe_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              w_load;

    // Ready looks through to downstream so a full pipe still moves every cycle.
    assign o_ready = !r_valid || i_ready;
    assign w_load  = i_valid && o_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule : elastic_pipe_stage
`default_nettype wire

// File: rtl/lead_one_placer_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : lead_one_placer_pipe
//  Purpose  : Rebuilds {1,payload} >> pos with sticky, two-stage elastic pipe.
//  Revision : 1.0  initial release
// ============================================================================
module lead_one_placer_pipe
    import pof_lod_pkg::*;
#(
    parameter  int WIDTH     = 16,
    localparam int LOG_WIDTH = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LOG_WIDTH-1:0] in_pos,
    input  logic [WIDTH-2:0]     in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_word,
    output logic                 out_sticky
);

    localparam int S1_W = WIDTH + 3;
    localparam int S2_W = WIDTH + 1;

    logic [WIDTH-1:0]     w_vec;
    logic [LOG_WIDTH-1:0] w_coarse_amt;
    logic [WIDTH-1:0]     w_coarse_word;
    logic                 w_coarse_sticky;
    logic [S1_W-1:0]      w_s1_in;
    logic [S1_W-1:0]      w_s1_data;
    logic                 w_s1_valid;
    logic                 w_s2_ready;

    logic [WIDTH-1:0]     w_s1_word;
    logic                 w_s1_sticky;
    logic [1:0]           w_s1_fine;
    logic [WIDTH-1:0]     w_fine_word;
    logic                 w_fine_sticky;
    logic [S2_W-1:0]      w_s2_in;
    logic [S2_W-1:0]      w_s2_data;

    // Coarse stage drops whole nibbles; the mask selects the bits falling off.
    assign w_vec           = {1'b1, in_payload};
    assign w_coarse_amt    = {in_pos[LOG_WIDTH-1:2], 2'b00};
    assign w_coarse_word   = w_vec >> w_coarse_amt;
    assign w_coarse_sticky = |(w_vec & ~({WIDTH{1'b1}} << w_coarse_amt));
    assign w_s1_in         = {w_coarse_word, w_coarse_sticky, in_pos[1:0]};

    elastic_pipe_stage #(.DATA_W(S1_W)) u_stage1 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_s1_in),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_ready),
        .o_data  (w_s1_data)
    );

    assign w_s1_word     = w_s1_data[S1_W-1:3];
    assign w_s1_sticky   = w_s1_data[2];
    assign w_s1_fine     = w_s1_data[1:0];
    assign w_fine_word   = w_s1_word >> w_s1_fine;
    assign w_fine_sticky = w_s1_sticky | (|(w_s1_word & ~({WIDTH{1'b1}} << w_s1_fine)));
    assign w_s2_in       = {w_fine_word, w_fine_sticky};

    elastic_pipe_stage #(.DATA_W(S2_W)) u_stage2 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ready),
        .i_data  (w_s2_in),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_s2_data)
    );

    assign out_word   = w_s2_data[S2_W-1:1];
    assign out_sticky = w_s2_data[0];

endmodule : lead_one_placer_pipe
`default_nettype wire

// File: tb/tb_lead_one_placer_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lead_one_placer_pipe
//  Purpose  : Directed self-checking bench for lead_one_placer_pipe (WIDTH=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_lead_one_placer_pipe;
    import pof_lod_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    lod_pos_t    in_pos;
    logic [14:0] in_payload;
    logic        out_valid;
    logic        out_ready;
    lod_word_t   out_word;
    logic        out_sticky;

    int n_checks = 0;
    int n_errors = 0;

    lead_one_placer_pipe #(.WIDTH(LOD_WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pos     (in_pos),
        .in_payload (in_payload),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_sticky (out_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic lod_word_t model_word(input int pos, input logic [14:0] pl);
        lod_word_t v;
        v = {1'b1, pl};
        return v >> pos;
    endfunction

    function automatic logic model_sticky(input int pos, input logic [14:0] pl);
        lod_word_t v;
        logic s;
        v = {1'b1, pl};
        s = 1'b0;
        for (int b = 0; b < pos; b++) s = s | v[b];
        return s;
    endfunction

    function automatic int lod(input lod_word_t w);
        for (int b = 15; b >= 0; b--)
            if (w[b]) return 15 - b;
        return 16;
    endfunction

    function automatic logic [14:0] b2b_payload(input int i);
        return 15'h5A5A ^ 15'(i * 1111);
    endfunction

    // Presents one word with out_ready high and checks the two-edge latency.
    task automatic send(input string tag, input int pos, input logic [14:0] pl,
                        input logic [15:0] exp_w, input logic exp_s);
        in_valid   = 1'b1;
        in_pos     = lod_pos_t'(pos);
        in_payload = pl;
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_early"}, out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_word"}, out_word, exp_w);
        check({tag, "_sticky"}, out_sticky, exp_s);
        @(posedge clk); #1;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_pos     = '0;
        in_payload = '0;
        out_ready  = 1'b1;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_word", out_word, 16'h0000);
        check("rst_out_sticky", out_sticky, 0);
        @(posedge clk); #1;

        // Basic and boundary vectors
        send("pos3",    3,  15'b101_0000_0000_0000, 16'h1A00, 1'b0);
        send("pos0",    0,  15'h7FFF,               16'hFFFF, 1'b0);
        send("pos15_1", 15, 15'h0001,               16'h0001, 1'b1);
        send("pos15_0", 15, 15'h0000,               16'h0001, 1'b0);
        send("pos5_1",  5,  15'h0001,               16'h0400, 1'b1);

        // Back-to-back, pos 0..15 with out_ready held high
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    in_valid   = 1'b1;
                    in_pos     = lod_pos_t'(i);
                    in_payload = b2b_payload(i);
                    @(negedge clk);
                    check("b2b_in_ready", in_ready, 1);
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                int got   = 0;
                int cyc   = 0;
                int first = -1;
                int last  = -1;
                while (got < 16 && cyc < 60) begin
                    @(negedge clk);
                    cyc++;
                    if (out_valid) begin
                        if (first < 0) first = cyc;
                        last = cyc;
                        check("b2b_word", out_word, model_word(got, b2b_payload(got)));
                        check("b2b_sticky", out_sticky, model_sticky(got, b2b_payload(got)));
                        check("b2b_lod", lod(out_word), got);
                        got++;
                    end
                end
                check("b2b_count", got, 16);
                check("b2b_rate", last - first, 15);
            end
        join
        @(posedge clk); #1;

        // Backpressure: A, B accepted; C held off until release
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_pos     = 4'd1;
        in_payload = 15'h4000;
        @(negedge clk);
        check("bp_acc_a", in_ready, 1);
        @(posedge clk); #1;
        in_pos     = 4'd7;
        in_payload = 15'h00FF;
        @(negedge clk);
        check("bp_acc_b", in_ready, 1);
        @(posedge clk); #1;
        in_pos     = 4'd12;
        in_payload = 15'h0800;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("bp_full_in_ready", in_ready, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_word", out_word, 16'h6000);
            check("bp_hold_sticky", out_sticky, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_out_a", out_word, 16'h6000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_out_b_valid", out_valid, 1);
        check("bp_out_b", out_word, 16'h0101);
        check("bp_out_b_sticky", out_sticky, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_out_c_valid", out_valid, 1);
        check("bp_out_c", out_word, 16'h0008);
        check("bp_out_c_sticky", out_sticky, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_drained", out_valid, 0);
        @(posedge clk); #1;

        // Reset mid-flight with two words stalled in the pipe
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_pos     = 4'd2;
        in_payload = 15'h1111;
        @(posedge clk); #1;
        in_pos     = 4'd9;
        in_payload = 15'h2222;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_pre_valid", out_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_out_valid", out_valid, 0);
        check("mid_in_ready", in_ready, 1);
        check("mid_out_word", out_word, 16'h0000);
        out_ready = 1'b1;
        @(posedge clk); #1;
        send("post_rst", 10, 15'h7C00, 16'h003F, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_rst_no_ghost", out_valid, 0);
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 0x0 expected 0x1");
        $fatal(1, "timeout");
    end

endmodule : tb_lead_one_placer_pipe
`default_nettype wire
